// File: rtl/range_rng.sv
// range_rng: bounded random-number generator.
// A free-running Fibonacci LFSR is masked down to the smallest all-ones
// window covering (max - min). Candidates outside the range are rejected
// and a new one is taken on the next cycle. After MAX_TRIES rejections the
// last candidate is halved, which always lands inside the range.
module range_rng #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] SEED     = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int              MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] random_number,
  output logic             range_err
);

  // Tap masks (bit n-1 for term x^n) for the supported widths.
  localparam logic [31:0] TAPS_ALL = (WIDTH == 8)  ? 32'h0000_00B8 :
                                     (WIDTH == 16) ? 32'h0000_D008 :
                                                     32'h8020_0003;
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam logic [8:0]       LAST_TRY = 9'(MAX_TRIES);

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] min_l;
  logic [WIDTH-1:0] max_l;
  logic [WIDTH-1:0] range_w;
  logic [WIDTH-1:0] mask_w;
  logic [WIDTH-1:0] cand;
  logic [7:0]       tries;
  logic             last_try;
  logic             fb;

  // Smear the highest set bit downward: gives the smallest 2^k-1 >= r.
  function automatic logic [WIDTH-1:0] fill_mask(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    m = r;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  assign fb       = ^(lfsr & TAPS);
  assign range_w  = max_l - min_l;
  assign mask_w   = fill_mask(range_w);
  assign cand     = lfsr & mask_w;
  assign last_try = (({1'b0, tries} + 9'd1) == LAST_TRY);

  // LFSR steps every cycle; a zero seed would lock it up, so SEED replaces it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr <= {lfsr[WIDTH-2:0], fb};
    end
  end

  // Bounds are captured once per accepted request and held until it completes.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      min_l <= min;
      max_l <= max;
    end
  end

  // Request FSM: accept in IDLE, draw/reject candidates in SAMPLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      valid         <= 1'b0;
      range_err     <= 1'b0;
      random_number <= '0;
      tries         <= '0;
    end else begin
      valid     <= 1'b0;
      range_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tries <= '0;
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          if (max_l < min_l) begin
            random_number <= min_l;
            valid         <= 1'b1;
            range_err     <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (cand <= range_w) begin
            random_number <= min_l + cand;
            valid         <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (last_try) begin
            // cand <= mask <= 2*range, so cand/2 never exceeds range.
            random_number <= min_l + (cand >> 1);
            valid         <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_rng.sv
// Testbench for range_rng (WIDTH=8). Main instance uses MAX_TRIES=8, a second
// instance uses MAX_TRIES=1 for the immediate-fallback case.
module tb_range_rng;

  localparam int MT = 8;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, seed_load, req;
  logic [7:0] seed_in, tb_min, tb_max;
  logic       busy, valid, range_err;
  logic [7:0] random_number;

  logic       seed_load1, req1;
  logic [7:0] seed_in1, min1, max1;
  logic       busy1, valid1, range_err1;
  logic [7:0] rn1;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         vcount = 0;
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  range_rng #(.WIDTH(8), .SEED(8'h01), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .min(tb_min), .max(tb_max), .busy(busy), .valid(valid),
    .random_number(random_number), .range_err(range_err)
  );

  range_rng #(.WIDTH(8), .SEED(8'h01), .MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .seed_load(seed_load1), .seed_in(seed_in1),
    .req(req1), .min(min1), .max(max1), .busy(busy1), .valid(valid1),
    .random_number(rn1), .range_err(range_err1)
  );

  // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
  function automatic logic [7:0] step8(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference model of one request starting from the LFSR value v1
  function automatic exp_t predict(input logic [7:0] v1, input logic [7:0] mn,
                                   input logic [7:0] mx, input int ntries);
    exp_t e;
    logic [7:0] rng, m, v, cand;
    e.res = mn; e.err = 1'b0; e.lat = 1;
    if (mx < mn) begin
      e.err = 1'b1;
      return e;
    end
    rng = mx - mn;
    m = 8'h00;
    while (m < rng) m = {m[6:0], 1'b1};
    v = v1;
    for (int t = 0; t < ntries; t++) begin
      if (t > 0) v = step8(v);
      cand = v & m;
      e.lat = t + 1;
      if (cand <= rng) begin
        e.res = mn + cand;
        return e;
      end
      e.res = mn + (cand >> 1);
    end
    return e;
  endfunction

  // Model LFSR tracking the main instance's inputs
  always @(posedge clk) begin
    if (!reset) lfsr_m <= 8'h01;
    else if (seed_load) lfsr_m <= (seed_in == 8'h00) ? 8'h01 : seed_in;
    else lfsr_m <= step8(lfsr_m);
  end

  always @(negedge clk) begin
    if (valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic drive_req(input logic [7:0] mn, input logic [7:0] mx,
                           input logic sl, input logic [7:0] si);
    req = 1'b1; tb_min = mn; tb_max = mx; seed_load = sl; seed_in = si;
    @(negedge clk);
    req = 1'b0; seed_load = 1'b0;
  endtask

  task automatic issue(input logic [7:0] mn, input logic [7:0] mx,
                       input logic sl, input logic [7:0] si);
    logic [7:0] v1;
    v1 = sl ? ((si == 8'h00) ? 8'h01 : si) : step8(lfsr_m);
    exp_q.push_back(predict(v1, mn, mx, MT));
    drive_req(mn, mx, sl, si);
  endtask

  task automatic wait_valid(input int limit, output int cyc, output bit got);
    got = 1'b0; cyc = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1'b1; cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (range_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", range_err); end
    tests++; if (random_number !== 8'h00) begin fails++; $display("FAIL reset_rn got %h want 00", random_number); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_value();
    int cyc; bit got; exp_t e;
    issue(8'h20, 8'h20, 1'b0, 8'h00);
    wait_valid(MT + 2, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || random_number !== e.res || random_number !== 8'h20 || range_err !== 1'b0 || cyc != e.lat)
      begin fails++; $display("FAIL single_value got rn=%h err=%b lat=%0d want rn=20 err=0 lat=%0d", random_number, range_err, cyc, e.lat); end
  endtask

  task automatic test_range_err();
    int cyc; bit got; exp_t e;
    issue(8'h50, 8'h10, 1'b0, 8'h00);
    wait_valid(MT + 2, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || random_number !== e.res || range_err !== 1'b1 || cyc != 1)
      begin fails++; $display("FAIL range_err got rn=%h err=%b lat=%0d want rn=%h err=1 lat=1", random_number, range_err, cyc, e.res); end
    @(negedge clk);
    tests++; if (valid !== 1'b0 || range_err !== 1'b0)
      begin fails++; $display("FAIL range_err_pulse got valid=%b err=%b want 0 0", valid, range_err); end
    @(negedge clk);
    tests++; if (random_number !== 8'h50)
      begin fails++; $display("FAIL rn_hold got %h want 50", random_number); end
  endtask

  task automatic test_fallback();
    exp_t e;
    exp_q.push_back('{res: 8'h7F, err: 1'b0, lat: 1});
    seed_load1 = 1'b1; seed_in1 = 8'hFF; req1 = 1'b1; min1 = 8'h00; max1 = 8'h80;
    @(negedge clk);
    seed_load1 = 1'b0; req1 = 1'b0;
    tests++; if (busy1 !== 1'b1 || valid1 !== 1'b0)
      begin fails++; $display("FAIL fallback_busy got busy=%b valid=%b want 1 0", busy1, valid1); end
    @(negedge clk);
    e = exp_q.pop_front();
    tests++; if (valid1 !== 1'b1 || rn1 !== e.res || range_err1 !== e.err)
      begin fails++; $display("FAIL fallback got valid=%b rn=%h err=%b want 1 %h %b", valid1, rn1, range_err1, e.res, e.err); end
  endtask

  task automatic test_zero_seed();
    int cyc; bit got; exp_t e;
    seed_load = 1'b1; seed_in = 8'h00;
    @(negedge clk);
    seed_load = 1'b0;
    issue(8'h00, 8'hFF, 1'b0, 8'h00);
    tests++; if (busy !== 1'b1)
      begin fails++; $display("FAIL zero_seed_busy got %b want 1", busy); end
    wait_valid(MT + 2, cyc, got);
    e = exp_q.pop_front();
    tests++; if (!got || random_number !== e.res || random_number !== 8'h02 || cyc != 1)
      begin fails++; $display("FAIL zero_seed got rn=%h lat=%0d want rn=02 lat=1", random_number, cyc); end
  endtask

  task automatic test_seed_during_sample();
    int cyc; bit got; exp_t e;
    // 0xFF & 0x7F = 0x7F > 0x40 rejects; reseeded 0x05 is then accepted
    exp_q.push_back('{res: 8'h15, err: 1'b0, lat: 2});
    drive_req(8'h10, 8'h50, 1'b1, 8'hFF);
    seed_load = 1'b1; seed_in = 8'h05; tb_min = 8'hAA; tb_max = 8'hBB;
    @(negedge clk);
    seed_load = 1'b0;
    tests++; if (valid !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("FAIL reject_step got valid=%b busy=%b want 0 1", valid, busy); end
    wait_valid(MT + 2, cyc, got);
    e = exp_q.pop_front();
    tests++; if (!got || random_number !== e.res || range_err !== e.err || cyc + 1 != e.lat)
      begin fails++; $display("FAIL seed_mid_sample got rn=%h err=%b lat=%0d want rn=%h err=%b lat=%0d", random_number, range_err, cyc + 1, e.res, e.err, e.lat); end
  endtask

  task automatic test_reset_abort();
    int cyc, v0; bit got; exp_t e;
    drive_req(8'h10, 8'h50, 1'b1, 8'hFF);
    tests++; if (busy !== 1'b1)
      begin fails++; $display("FAIL abort_busy_pre got %b want 1", busy); end
    v0 = vcount;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || valid !== 1'b0 || random_number !== 8'h00 || range_err !== 1'b0)
      begin fails++; $display("FAIL abort_state got busy=%b valid=%b rn=%h err=%b want 0 0 00 0", busy, valid, random_number, range_err); end
    reset = 1'b1;
    // LFSR restarts at SEED: first evaluated value is step(0x01) = 0x02
    exp_q.push_back('{res: 8'h02, err: 1'b0, lat: 1});
    drive_req(8'h00, 8'hFF, 1'b0, 8'h00);
    wait_valid(MT + 2, cyc, got);
    e = exp_q.pop_front();
    tests++; if (!got || random_number !== e.res || cyc != e.lat)
      begin fails++; $display("FAIL abort_lfsr_seed got rn=%h lat=%0d want rn=%h lat=%0d", random_number, cyc, e.res, e.lat); end
    repeat (10) @(negedge clk);
    #1;
    tests++; if (vcount - v0 != 1)
      begin fails++; $display("FAIL abort_valid_count got %0d want 1", vcount - v0); end
  endtask

  task automatic test_back_to_back();
    logic exp_v, exp_b;
    tb_min = 8'h30; tb_max = 8'h30; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 1); exp_b = (i % 2 == 0);
      tests++; if (valid !== exp_v || busy !== exp_b || (exp_v && random_number !== 8'h30))
        begin fails++; $display("FAIL back_to_back[%0d] got valid=%b busy=%b rn=%h want %b %b 30", i, valid, busy, random_number, exp_v, exp_b); end
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, v0, mn, mx, nbad;
    bit got; exp_t e; logic sl; logic [7:0] si;
    localparam int N = 10000;
    nbad = 0;
    v0 = vcount;
    for (int i = 0; i < N; i++) begin
      mn = $urandom_range(255, 0);
      mx = $urandom_range(255, mn);
      if (i % 50 == 0) mx = mn;
      if (i % 50 == 1) begin mn = 0; mx = 255; end
      sl = ($urandom_range(7, 0) == 0);
      si = 8'($urandom_range(255, 0));
      if (i % 97 == 0) si = 8'h00;
      issue(8'(mn), 8'(mx), sl, si);
      wait_valid(MT + 2, cyc, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || random_number !== e.res || range_err !== 1'b0 || cyc != e.lat) begin
        fails++; nbad++;
        if (nbad < 10) $display("FAIL random[%0d] got rn=%h err=%b lat=%0d want rn=%h err=0 lat=%0d", i, random_number, range_err, cyc, e.res, e.lat);
      end
      tests++;
      if (int'(random_number) < mn || int'(random_number) > mx) begin
        fails++; nbad++;
        if (nbad < 10) $display("FAIL random_bounds[%0d] got %0d want %0d..%0d", i, random_number, mn, mx);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (vcount - v0 != N)
      begin fails++; $display("FAIL random_valid_count got %0d want %0d", vcount - v0, N); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; seed_load = 1'b0; seed_in = 8'h00; req = 1'b0;
    tb_min = 8'h00; tb_max = 8'h00;
    seed_load1 = 1'b0; seed_in1 = 8'h00; req1 = 1'b0; min1 = 8'h00; max1 = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_value();
    test_range_err();
    test_fallback();
    test_zero_seed();
    test_seed_during_sample();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/range_rng.md
RANGE_RNG -- requirements
Module: range_rng

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data/LFSR width; legal values 8, 16, 32 only.
REQ-002 The block SHALL have parameter SEED, default 1, LFSR value after reset and on zero-seed substitution; nonzero.
REQ-003 The block SHALL have parameter MAX_TRIES, default 8, rejections allowed per request before fallback; range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 seed_load  input  1  load seed_in into LFSR this edge.
REQ-007 seed_in  input  WIDTH  seed value for seed_load.
REQ-008 req  input  1  request one random number; honoured only in IDLE.
REQ-009 min  input  WIDTH  inclusive lower bound, captured with req.
REQ-010 max  input  WIDTH  inclusive upper bound, captured with req.
REQ-011 busy  output  1  high while a request is in progress (state != IDLE).
REQ-012 valid  output  1  one-cycle pulse; random_number updated.
REQ-013 random_number  output  WIDTH  result, held until next valid.
REQ-014 range_err  output  1  one-cycle pulse with valid when captured max < min.

Function
REQ-015 LFSR SHALL be a Fibonacci shift-left, feedback into bit 0, stepping every cycle regardless of state.
REQ-016 Taps SHALL be: WIDTH 8: x^8+x^6+x^5+x^4+1; 16: x^16+x^15+x^13+x^4+1; 32: x^32+x^22+x^2+x^1+1.
REQ-017 seed_load SHALL set LFSR to seed_in, or to SEED when seed_in == 0; seed_load overrides the step that edge.
REQ-018 FSM states SHALL be IDLE and SAMPLE only.
REQ-019 IDLE: req=1 at an edge SHALL latch min/max, clear try counter, go to SAMPLE; req ignored in SAMPLE.
REQ-020 range = max_l - min_l (WIDTH bits, unsigned); mask = smallest 2^k-1 >= range (mask=0 when range=0).
REQ-021 SAMPLE evaluation SHALL use the LFSR value present before the edge: cand = lfsr & mask.
REQ-022 If max_l < min_l: random_number <= min_l, valid=1, range_err=1, go IDLE.
REQ-023 Else if cand <= range: random_number <= min_l + cand, valid=1, go IDLE.
REQ-024 Else if try counter + 1 == MAX_TRIES: random_number <= min_l + (cand >> 1), valid=1, go IDLE.
REQ-025 Else: increment try counter, remain in SAMPLE, valid=0.
REQ-026 Latency: req sampled at edge k -> valid at edge k+1 minimum, k+MAX_TRIES maximum.
REQ-027 Results SHALL always lie in [min_l, max_l] when max_l >= min_l; sums never wrap.
REQ-028 seed_load concurrent with req or during SAMPLE SHALL NOT abort the request; evaluation continues on new sequence.
REQ-029 min/max changes after capture SHALL have no effect on the pending request.
REQ-030 Back-to-back: req held high SHALL start a new request on the edge after valid (one IDLE cycle).

Reset
REQ-031 reset=0 at an edge SHALL set LFSR=SEED, state=IDLE, try counter=0, valid=0, range_err=0, random_number=0, busy=0.
REQ-032 Reset SHALL take priority over seed_load and req; a request in SAMPLE is discarded with no valid.

Verification
REQ-033 WIDTH=8: min=max=0x20, req one cycle -> valid one edge later, random_number=0x20, range_err=0.
REQ-034 WIDTH=8: min=0x50, max=0x10 -> valid and range_err pulse together one edge after req, random_number=0x50.
REQ-035 WIDTH=8, MAX_TRIES=1: seed_load seed_in=0xFF with req, min=0x00, max=0x80 -> next edge valid, random_number=0x7F.
REQ-036 WIDTH=8: seed_load seed_in=0x00 -> LFSR=SEED(0x01); min=0x00, max=0xFF req -> random_number equals LFSR value at evaluation.
REQ-037 Reset asserted while busy=1 -> next edge busy=0, valid=0, random_number=0x00, LFSR=SEED; no valid for aborted request.
REQ-038 10,000 random requests, random min<=max -> every result in [min,max], valid pulses exactly once per accepted req.
